// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the shared BRAM port arbiter.
// Slave modport is the arbiter's view; master is the clients/BRAM view.
interface bram_port_arbiter_if #(
    parameter int unsigned memaddrbit = 14,
    parameter int unsigned width      = 8,
    parameter int unsigned nreq       = 4
);
    logic [nreq-1:0]            req;
    logic [nreq-1:0]            req_we;
    logic [nreq*memaddrbit-1:0] req_addr;
    logic [nreq*width-1:0]      req_wdata;
    logic [nreq-1:0]            gnt;
    logic [nreq-1:0]            rvalid;
    logic [width-1:0]           rdata;
    logic                       bram_wea;
    logic [memaddrbit-1:0]      bram_addr;
    logic [width-1:0]           bram_din;
    logic [width-1:0]           bram_dout;
    logic                       busy;

    modport slave (
        input  req, req_we, req_addr, req_wdata, bram_dout,
        output gnt, rvalid, rdata, bram_wea, bram_addr, bram_din, busy
    );

    modport master (
        output req, req_we, req_addr, req_wdata, bram_dout,
        input  gnt, rvalid, rdata, bram_wea, bram_addr, bram_din, busy
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Burst arbiter sharing one BRAM port: round-robin among requesters 0..nreq-2,
// debug requester nreq-1 wins at arbitration points; reads return tagged one cycle later.
module bram_port_arbiter #(
    parameter int unsigned memaddrbit = 14,
    parameter int unsigned width      = 8,
    parameter int unsigned nreq       = 4,
    parameter int unsigned max_burst  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   bus
);
    localparam int unsigned OW   = $clog2(nreq);
    localparam int unsigned CW   = (max_burst > 1) ? $clog2(max_burst) : 1;
    localparam int unsigned NRR  = nreq - 1;
    localparam logic [OW-1:0] DBG      = OW'(nreq - 1);
    localparam logic [OW-1:0] RR_LAST  = OW'(nreq - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(max_burst - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]      state, state_n;
    logic [OW-1:0]   owner, owner_n;
    logic [OW-1:0]   rr_ptr, rr_n;
    logic [CW-1:0]   burst_cnt, cnt_n;
    logic [nreq-1:0] rvalid_q, rvalid_n;
    logic [nreq-1:0] gnt_c;
    logic            grant_c;
    logic [OW-1:0]   pick_c;

    logic [memaddrbit-1:0] addr_arr  [nreq];
    logic [width-1:0]      wdata_arr [nreq];

    // Unpack the flat per-requester buses into indexable arrays
    always_comb begin
        for (int i = 0; i < int'(nreq); i++) begin
            addr_arr[i]  = bus.req_addr[i*memaddrbit +: memaddrbit];
            wdata_arr[i] = bus.req_wdata[i*width +: width];
        end
    end

    // Round-robin pick among the non-debug requesters, starting at rr_ptr
    always_comb begin
        int unsigned idx;
        logic        found;
        pick_c = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NRR; k++) begin
            idx = (32'(rr_ptr) + k) % NRR;
            if (!found && bus.req[idx]) begin
                pick_c = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign grant_c = (state == S_OWN) && bus.req[owner];

    // Next-state, ownership and read-tag logic
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_n     = rr_ptr;
        cnt_n    = burst_cnt;
        rvalid_n = '0;
        gnt_c    = '0;
        if (grant_c) begin
            gnt_c[owner] = 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    state_n = S_OWN;
                    cnt_n   = '0;
                    owner_n = bus.req[DBG] ? DBG : pick_c;
                end
            end
            S_OWN: begin
                if (grant_c) begin
                    cnt_n = burst_cnt + CW'(1);
                    if (!bus.req_we[owner]) begin
                        rvalid_n[owner] = 1'b1;
                    end
                end
                if (!bus.req[owner] || (grant_c && (burst_cnt == CNT_LAST))) begin
                    state_n = S_GAP;
                    if (owner != DBG) begin
                        rr_n = (owner == RR_LAST) ? '0 : owner + OW'(1);
                    end
                end
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            rvalid_q  <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_n;
            burst_cnt <= cnt_n;
            rvalid_q  <= rvalid_n;
        end
    end

    // BRAM side is driven straight from the granted owner's slice, zero otherwise
    assign bus.gnt       = gnt_c;
    assign bus.bram_wea  = grant_c & bus.req_we[owner];
    assign bus.bram_addr = grant_c ? addr_arr[owner]  : '0;
    assign bus.bram_din  = grant_c ? wdata_arr[owner] : '0;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = (|rvalid_q) ? bus.bram_dout : '0;
    assign bus.busy      = (state == S_OWN);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: cycle tables plus hand sequences
// for max-burst wrap, round-robin order and mid-burst reset.
module tb_bram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.memaddrbit(14), .width(8), .nreq(4)) bif ();

    bram_port_arbiter #(
        .memaddrbit(14), .width(8), .nreq(4), .max_burst(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Synchronous read-first BRAM model with a preload path
    logic [7:0]  mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bif.bram_wea) mem[bif.bram_addr] <= bif.bram_din;
        bif.bram_dout <= mem[bif.bram_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rb;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  gnt;
        logic [3:0]  rvalid;
        logic [7:0]  rdata;
        logic        busy;
        logic        wea;
        logic [13:0] baddr;
        logic [7:0]  din;
    } vec_t;

    function automatic vec_t mk(input logic rb, input logic [3:0] r, input logic [3:0] w,
                                input int a, input int wd, input logic [3:0] g,
                                input logic [3:0] rv, input int rd, input logic b,
                                input logic e, input int ba, input int di);
        vec_t v;
        v.rb = rb; v.req = r; v.we = w; v.addr = 14'(a); v.wdata = 8'(wd);
        v.gnt = g; v.rvalid = rv; v.rdata = 8'(rd); v.busy = b; v.wea = e;
        v.baddr = 14'(ba); v.din = 8'(di);
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w, input int a, input int wd);
        bif.req       = r;
        bif.req_we    = w;
        bif.req_addr  = {4{14'(a)}};
        bif.req_wdata = {4{8'(wd)}};
    endtask

    function automatic logic [63:0] outs();
        return 64'({bif.gnt, bif.rvalid, bif.rdata, bif.busy, bif.bram_wea,
                    bif.bram_addr, bif.bram_din});
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        drive(4'b0, 4'b0, 0, 0);
        @(posedge clk);
        #1 check("reset_state", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload(input int a, input int d);
        pl_en = 1'b1; pl_addr = 14'(a); pl_data = 8'(d);
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    vec_t vt [27];

    initial begin
        int runs[$];
        int b_own[$], b_len[$], b_gap[$];
        int seen[3];
        int k, bad, wea_cnt, cur, len, low, idx;
        logic started, inb;
        logic [7:0] rd_m;

        // Test 1: four reads by requester 0
        vt[0]  = mk(1, 4'b0001, 4'b0, 100, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[1]  = mk(0, 4'b0001, 4'b0, 100, 0, 4'b0001, 4'b0000,  0, 1, 0, 100, 0);
        vt[2]  = mk(0, 4'b0001, 4'b0, 101, 0, 4'b0001, 4'b0001, 20, 1, 0, 101, 0);
        vt[3]  = mk(0, 4'b0001, 4'b0, 102, 0, 4'b0001, 4'b0001, 40, 1, 0, 102, 0);
        vt[4]  = mk(0, 4'b0001, 4'b0, 103, 0, 4'b0001, 4'b0001, 60, 1, 0, 103, 0);
        vt[5]  = mk(0, 4'b0000, 4'b0,   0, 0, 4'b0000, 4'b0001, 80, 1, 0,   0, 0);
        vt[6]  = mk(0, 4'b0000, 4'b0,   0, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[7]  = mk(0, 4'b0000, 4'b0,   0, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        // Test 4: debug rises mid-burst, wins next arbitration, then rr resumes at 2
        vt[8]  = mk(1, 4'b0010, 4'b0, 200, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[9]  = mk(0, 4'b0010, 4'b0, 200, 0, 4'b0010, 4'b0000,  0, 1, 0, 200, 0);
        vt[10] = mk(0, 4'b1010, 4'b0, 200, 0, 4'b0010, 4'b0010, 11, 1, 0, 200, 0);
        vt[11] = mk(0, 4'b1010, 4'b0, 200, 0, 4'b0010, 4'b0010, 11, 1, 0, 200, 0);
        vt[12] = mk(0, 4'b1100, 4'b0, 300, 0, 4'b0000, 4'b0010, 11, 1, 0,   0, 0);
        vt[13] = mk(0, 4'b1100, 4'b0, 300, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[14] = mk(0, 4'b1100, 4'b0, 300, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[15] = mk(0, 4'b1100, 4'b0, 300, 0, 4'b1000, 4'b0000,  0, 1, 0, 300, 0);
        vt[16] = mk(0, 4'b0101, 4'b0, 300, 0, 4'b0000, 4'b1000, 90, 1, 0,   0, 0);
        vt[17] = mk(0, 4'b0101, 4'b0, 300, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[18] = mk(0, 4'b0101, 4'b0, 300, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        vt[19] = mk(0, 4'b0101, 4'b0, 300, 0, 4'b0100, 4'b0000,  0, 1, 0, 300, 0);
        vt[20] = mk(0, 4'b0000, 4'b0,   0, 0, 4'b0000, 4'b0100, 90, 1, 0,   0, 0);
        vt[21] = mk(0, 4'b0000, 4'b0,   0, 0, 4'b0000, 4'b0000,  0, 0, 0,   0, 0);
        // Test 6: requester 2 writes 3008 then reads it back
        vt[22] = mk(1, 4'b0100, 4'b0100, 3008, 80, 4'b0000, 4'b0000,  0, 0, 0,    0,  0);
        vt[23] = mk(0, 4'b0100, 4'b0100, 3008, 80, 4'b0100, 4'b0000,  0, 1, 1, 3008, 80);
        vt[24] = mk(0, 4'b0100, 4'b0000, 3008,  0, 4'b0100, 4'b0000,  0, 1, 0, 3008,  0);
        vt[25] = mk(0, 4'b0000, 4'b0000,    0,  0, 4'b0000, 4'b0100, 80, 1, 0,    0,  0);
        vt[26] = mk(0, 4'b0000, 4'b0000,    0,  0, 4'b0000, 4'b0000,  0, 0, 0,    0,  0);

        drive(4'b0, 4'b0, 0, 0);
        bif.bram_dout = '0;
        preload(100, 20); preload(101, 40); preload(102, 60); preload(103, 80);
        preload(200, 11); preload(300, 90);

        for (int i = 0; i < 27; i++) begin
            if (vt[i].rb) do_reset();
            @(posedge clk);
            #1 drive(vt[i].req, vt[i].we, 32'(vt[i].addr), 32'(vt[i].wdata));
            @(negedge clk);
            rd_m = (vt[i].rvalid != 4'b0) ? bif.rdata : 8'h00;
            check($sformatf("vec%0d", i),
                  64'({bif.gnt, bif.rvalid, rd_m, bif.busy, bif.bram_wea, bif.bram_addr, bif.bram_din}),
                  64'({vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].busy, vt[i].wea, vt[i].baddr, vt[i].din}));
        end

        // Test 2: continuous writer hits the max_burst limit twice
        do_reset();
        k = 0; bad = 0; wea_cnt = 0; started = 1'b0; cur = 0; len = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1 drive((k < 32) ? 4'b0100 : 4'b0000, 4'b0100, 3095 + k, k);
            @(negedge clk);
            if (bif.gnt != 4'b0000 && bif.gnt != 4'b0100) bad++;
            if (bif.bram_wea != bif.gnt[2]) bad++;
            if (bif.bram_wea) wea_cnt++;
            if (bif.gnt[2]) k++;
            if (!started) begin
                if (bif.gnt[2]) begin started = 1'b1; cur = 1; len = 1; end
            end else if (int'(bif.gnt[2]) == cur) begin
                len++;
            end else begin
                runs.push_back(len); cur = int'(bif.gnt[2]); len = 1;
            end
        end
        check("wr_gnt_wea_consistency", 64'(bad), 64'd0);
        check("wr_wea_pulses", 64'(wea_cnt), 64'd32);
        check("wr_burst1_len", 64'((runs.size() > 0) ? runs[0] : -1), 64'd16);
        check("wr_gap_len",    64'((runs.size() > 1) ? runs[1] : -1), 64'd2);
        check("wr_burst2_len", 64'((runs.size() > 2) ? runs[2] : -1), 64'd16);
        for (int a = 0; a < 32; a++)
            check($sformatf("wr_mem%0d", 3095 + a), 64'(mem[3095 + a]), 64'(a));

        // Test 3: three readers, two accesses per burst, round-robin order
        do_reset();
        for (int i = 0; i < 3; i++) seen[i] = 0;
        low = 0; inb = 1'b0;
        for (int c = 0; c < 36; c++) begin
            logic [3:0] r;
            @(posedge clk);
            r = 4'b0;
            if (c < 33) begin
                for (int i = 0; i < 3; i++) begin
                    if (seen[i] >= 2) seen[i] = 0;
                    else r[i] = 1'b1;
                end
            end
            #1 drive(r, 4'b0, 50, 0);
            @(negedge clk);
            if (bif.gnt != 4'b0) begin
                check("rr_gnt_onehot", 64'($onehot(bif.gnt)), 64'd1);
                idx = 0;
                for (int i = 0; i < 4; i++) if (bif.gnt[i]) idx = i;
                if (!inb || b_own.size() == 0 || idx != b_own[b_own.size()-1]) begin
                    b_own.push_back(idx); b_len.push_back(1); b_gap.push_back(low);
                end else begin
                    b_len[b_len.size()-1]++;
                end
                if (idx < 3) seen[idx]++;
                inb = 1'b1; low = 0;
            end else begin
                inb = 1'b0; low++;
            end
        end
        check("rr_burst_count_ge6", 64'(b_own.size() >= 6), 64'd1);
        for (int b = 0; b < 6 && b < b_own.size(); b++) begin
            check($sformatf("rr_owner%0d", b), 64'(b_own[b]), 64'(b % 3));
            check($sformatf("rr_len%0d", b), 64'(b_len[b]), 64'd2);
            if (b > 0) check($sformatf("rr_gap%0d", b), 64'(b_gap[b]), 64'd3);
        end

        // Test 5: async reset between a read grant and its return
        do_reset();
        @(posedge clk);
        #1 drive(4'b0001, 4'b0, 101, 0);
        @(negedge clk);
        check("ar_idle_nognt", 64'(bif.gnt), 64'd0);
        @(negedge clk);
        check("ar_gnt", 64'({bif.gnt, bif.bram_addr}), 64'({4'b0001, 14'd101}));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ar_abort_outputs", outs(), 64'd0);
        @(negedge clk);
        check("ar_hold_rvalid", 64'({bif.rvalid, bif.gnt, bif.bram_wea}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("ar_rel_idle", 64'({bif.gnt, bif.busy}), 64'd0);
        @(negedge clk);
        check("ar_rel_gnt", 64'({bif.gnt, bif.busy, bif.bram_addr}), 64'({4'b0001, 1'b1, 14'd101}));
        @(posedge clk);
        #1 drive(4'b0, 4'b0, 0, 0);
        @(negedge clk);
        check("ar_rel_return", 64'({bif.rvalid, bif.rdata}), 64'({4'b0001, 8'd40}));
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single BRAM port between four requesters:
  - 0 = input-buffer loader (read)
  - 1 = weight-buffer loader (read)
  - 2 = output writeback (write)
  - 3 = debug bram check (read)
- Grants burst ownership with round-robin fairness among requesters 0-2.
- Requester 3 has top priority, but only at arbitration points; it never preempts a running burst.
- Sits between the CNN controller/buffers and the BRAM. Returns read data tagged to the owner one cycle after each read access.

Parameters:
- memaddrbit, 14, BRAM address width
- width, 8, BRAM data width
- nreq, 4, number of requesters (fixed at 4; index 3 = debug)
- max_burst, 16, max accesses per grant before forced re-arbitration

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous active-low reset
- req  in  nreq  per-requester access request; held high while accesses pending
- req_we  in  nreq  per-requester write enable (1 = write, 0 = read), sampled with req
- req_addr  in  nreq*memaddrbit  per-requester address, slice i = requester i
- req_wdata  in  nreq*width  per-requester write data
- gnt  out  nreq  one-hot; gnt[i]=1 means requester i's access executes this cycle
- rvalid  out  nreq  one-hot; read data for requester i valid on rdata this cycle
- rdata  out  width  read data returned from BRAM
- bram_wea  out  1  BRAM write enable
- bram_addr  out  memaddrbit  BRAM address
- bram_din  out  width  BRAM write data
- bram_dout  in  width  BRAM read data, synchronous, 1-cycle latency
- busy  out  1  high while state = OWN

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, owner 0, rr_ptr 0, burst_cnt 0
  - gnt, rvalid, bram_wea, bram_addr, bram_din, rdata, busy all 0
- States: IDLE, OWN, GAP.
- IDLE:
  - If req[3]=1, owner <= 3.
  - Else owner <= first i in {0,1,2} with req[i]=1, searching from rr_ptr upward and wrapping 2->0.
  - If any req, go to OWN with burst_cnt <= 0. No gnt is asserted in IDLE, so first grant latency is 1 cycle after req is seen.
- OWN:
  - gnt[owner] = req[owner] (combinational).
  - When gnt is high:
    - bram_addr/bram_we/bram_din are driven combinationally from the owner's slice.
    - burst_cnt increments.
    - When gnt is low, BRAM outputs are 0.
  - Exit to GAP when req[owner]=0, or when a grant occurs with burst_cnt = max_burst-1 (exactly max_burst accesses).
  - If owner is in {0,1,2}, rr_ptr <= owner+1 mod 3 on exit. A debug owner leaves rr_ptr unchanged.
- GAP: exactly one idle cycle with no gnt, then IDLE. This guarantees one re-arbitration cycle between bursts.
- Read return:
  - Each granted read registers its tag; the next cycle, rvalid[tag]=1 and rdata = bram_dout.
  - A write produces no rvalid.
  - A read return in the GAP/IDLE cycle after the last access is still delivered.
- Simultaneous events:
  - req rising for a non-owner during OWN is ignored until the next IDLE.
  - The owner dropping req in the same cycle max_burst is reached gives a single transition to GAP.
- req_we or address changes mid-burst are legal and take effect per access.
- Reset mid-burst aborts immediately:
  - Any pending rvalid is discarded.
  - No spurious bram_wea.
- Throughput: a steady single requester gets max_burst accesses per max_burst+2 cycles.

Test Plan:
- Reset, then req[0]=1 reading addr 100..103 (4 cycles) with bram preloaded 20,40,60,80:
  - gnt[0] high cycles 2-5.
  - rvalid[0] cycles 3-6 with rdata 20,40,60,80.
  - busy drops after req falls.
- req[2] held continuously, writes addr 3095+k, data k:
  - Exactly 16 bram_wea pulses, then gnt low 2 cycles (GAP, IDLE), then a new 16-access burst.
  - BRAM holds 3095..3110 = 0..15.
- req[0], req[1], req[2] all held, each 2-access bursts:
  - Grant order 0,1,2,0,1,2 with one GAP cycle between each.
  - rr_ptr wrap verified.
- req[1] bursting while req[3] rises mid-burst:
  - No preemption.
  - After req[1] drops, GAP, IDLE, then owner = 3 even though rr_ptr points at 2.
  - rvalid[3] returns the checked word.
- Async reset asserted between a read grant and its return:
  - rvalid stays 0, all outputs 0 immediately.
  - After release with req[0]=1, first gnt appears 1 cycle after IDLE.
- Mixed read/write burst by requester 2: write addr 3008 = 80, then read 3008:
  - rvalid[2] with rdata 80 on the cycle after the read grant.
